sync_bank: RTL and testbench
============================

# sync_bank

Parametrised multi-channel input synchronizer that replaces the single-bit `sync_low`/`sync_high` pair. It brings WIDTH independent asynchronous inputs into the `clk` domain through a configurable flip-flop chain, with a per-channel reset value. It produces one-cycle rise/fall pulses per channel. It optionally applies a per-channel stability filter that rejects short glitches. It sits directly behind chip-level pins (buttons, serial lines, handshake strobes) ahead of any FSM that samples them.

## Interface
Parameters:
- WIDTH, 4, number of independent channels (≥1)
- STAGES, 2, flip-flops in each synchronizer chain (≥2; elaboration error if <2)
- RESET_VAL, {WIDTH{1'b0}}, per-channel reset/idle value; replaces the low/high variant split
- FILTER_CNT, 3, consecutive cycles a new value must persist before acceptance (≥1); used only with the filter compiled in

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- async_in  in  WIDTH  asynchronous inputs, no timing relation to clk
- sync_out  out  WIDTH  synchronized (and optionally filtered) value
- rise  out  WIDTH  one-cycle pulse, channel went 0→1 on sync_out
- fall  out  WIDTH  one-cycle pulse, channel went 1→0 on sync_out

## Operation
- Per channel: a chain of STAGES flops (s[0] samples async_in[i]), all reset to RESET_VAL[i]. No logic between chain flops.
- Without filter, sync_out[i] is the registered output of s[STAGES-1].
- prev[i] register holds sync_out[i] from the previous cycle and resets to RESET_VAL[i].
  - rise = sync_out & ~prev
  - fall = ~sync_out & prev
  - rise and fall are combinational from registers only. They are never both high on one channel.
- Filter (when compiled in), per channel:
  - Registers: out[i] and a counter cnt[i] of width $clog2(FILTER_CNT+1).
  - On each edge where s[STAGES-1] == out[i]: cnt <= 0.
  - Otherwise, if cnt+1 == FILTER_CNT: out <= s[STAGES-1] and cnt <= 0. Otherwise cnt <= cnt+1.
  - sync_out = out. Reset: out = RESET_VAL[i], cnt = 0.
- Channels are fully independent. Simultaneous changes on any subset behave as each channel alone.
- Reset, including mid-operation, immediately forces:
  - all stages, prev and out to RESET_VAL
  - all cnt to 0
  - sync_out = RESET_VAL, rise = fall = 0
- No pulses are generated on reset release.
- A setup/hold violation on s[0] resolves to either the old or new value. The RTL never produces X on sync_out.

## Timing
- async_in changed mid-cycle, stable thereafter. E1 is the first rising edge that samples the new value.
- Without filter: sync_out changes after E_STAGES (latency STAGES edges). rise/fall are high for exactly the cycle following E_STAGES.
- With filter: sync_out changes after E_(STAGES+FILTER_CNT). A value at s[STAGES-1] lasting fewer than FILTER_CNT cycles never reaches sync_out and produces no pulse.
- A change inside the setup/hold window of E1 may be captured one edge late, so latency is N or N+1. Benches accept either.
- Back-to-back toggles every STAGES+1 cycles (no filter) each produce their own pulse. Pulses never merge or stretch beyond one cycle.

## Configuration
- SYNC_BANK_FILTER_EN defined: filter stage present, FILTER_CNT honoured, latency STAGES+FILTER_CNT.
- SYNC_BANK_FILTER_EN undefined: no out/cnt registers, FILTER_CNT ignored, latency STAGES.

## Test plan
Parameters for all scenarios: WIDTH=4, STAGES=2, RESET_VAL=4'b0101, FILTER_CNT=3.
- Reset: assert rst mid-cycle with async_in=4'b1010 → sync_out=4'b0101 immediately, rise=fall=0. Release rst with async_in=4'b0101 → no pulses for 5 cycles.
- Latency, no filter: async_in 4'b0101→4'b0111 at a negedge → sync_out=4'b0111 after 2nd rising edge. rise=4'b0010 for exactly one cycle, fall=0.
- Multi-channel: async_in 4'b0101→4'b1010 → after 2 edges, rise=4'b1010 and fall=4'b0101 in the same single cycle.
- Violations: change bit0 at 0.095 ns before an edge, and separately 0.05 ns after an edge → sync_out[0] correct after 2 or 3 edges, never X.
- Filter on, glitch: bit1 pulsed high for 2 cycles → sync_out stays 4'b0101, no rise/fall.
- Filter on, sustained change: bit1 held high → sync_out[1]=1 after exactly 5 edges, rise[1] for one cycle. rst asserted at edge 4 instead → cnt cleared, sync_out=4'b0101, no pulse.

Source files
------------

// File: rtl/sync_bank.sv
// sync_bank: WIDTH-channel asynchronous input synchronizer with per-channel reset value and rise/fall pulses.
// Optional glitch filter compiled in with `define SYNC_BANK_FILTER_EN.
`timescale 1ns/1ps
module sync_bank #(
  parameter int                WIDTH      = 4,
  parameter int                STAGES     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
  parameter int                FILTER_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_bank: STAGES must be at least 2");
  end
  if (FILTER_CNT < 1) begin : g_bad_filter
    $error("sync_bank: FILTER_CNT must be at least 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_bank: WIDTH must be at least 1");
  end

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  logic [WIDTH-1:0] s [STAGES];
  logic [WIDTH-1:0] chain_out;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) s[k] <= RESET_VAL;
    end else begin
      s[0] <= async_in;
      for (int k = 1; k < STAGES; k++) s[k] <= s[k-1];
    end
  end

  assign chain_out = s[STAGES-1];

`ifdef SYNC_BANK_FILTER_EN
  localparam int              CW       = $clog2(FILTER_CNT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CNT - 1);

  logic [WIDTH-1:0] filt_q;
  logic [CW-1:0]    cnt_q [WIDTH];

  // A new level is accepted only after FILTER_CNT consecutive mismatching edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (chain_out[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= chain_out[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign sync_out = filt_q;
`else
  assign sync_out = chain_out;
`endif

  // prev resets to the idle value, so reset release never produces an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= RESET_VAL;
    else     prev_q <= sync_out;
  end

  assign rise = sync_out & ~prev_q;
  assign fall = ~sync_out & prev_q;

endmodule

// File: tb/tb_sync_bank.sv
// Directed self-checking bench for sync_bank (WIDTH=4, STAGES=2, RESET_VAL=4'b0101, FILTER_CNT=3).
// Filter scenarios run when SYNC_BANK_FILTER_EN is defined; plain-latency scenarios otherwise.
`timescale 1ns/1ps
module tb_sync_bank;

  localparam int         WIDTH      = 4;
  localparam int         STAGES     = 2;
  localparam int         FILTER_CNT = 3;
  localparam logic [3:0] RV         = 4'b0101;
`ifdef SYNC_BANK_FILTER_EN
  localparam int         LAT        = STAGES + FILTER_CNT;
`else
  localparam int         LAT        = STAGES;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] async_in = RV;
  logic [3:0] sync_out;
  logic [3:0] rise;
  logic [3:0] fall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_bank #(
    .WIDTH      (WIDTH),
    .STAGES     (STAGES),
    .RESET_VAL  (RV),
    .FILTER_CNT (FILTER_CNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .async_in (async_in),
    .sync_out (sync_out),
    .rise     (rise),
    .fall     (fall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    async_in = RV;
    repeat (3) step();
    checks++;
    if (sync_out !== RV) begin errors++; $display("FAIL reset_sync got %b expected %b", sync_out, RV); end
    checks++;
    if ({rise, fall} !== 8'h00) begin errors++; $display("FAIL reset_pulses got rise=%b fall=%b expected 0", rise, fall); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (sync_out !== RV || rise !== 4'b0 || fall !== 4'b0) begin
        errors++; $display("FAIL release_idle cyc%0d got sync=%b rise=%b fall=%b expected sync=%b no pulses", c, sync_out, rise, fall, RV);
      end
    end
    // Load a different value, then reset mid-cycle while the inputs still differ.
    @(negedge clk); async_in = 4'b1010;
    repeat (LAT + 1) step();
    checks++;
    if (sync_out !== 4'b1010) begin errors++; $display("FAIL reset_preload got %b expected 1010", sync_out); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (sync_out !== RV) begin errors++; $display("FAIL midop_reset_sync got %b expected %b", sync_out, RV); end
    checks++;
    if ({rise, fall} !== 8'h00) begin errors++; $display("FAIL midop_reset_pulses got rise=%b fall=%b expected 0", rise, fall); end
    async_in = RV;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (sync_out !== RV || rise !== 4'b0 || fall !== 4'b0) begin
        errors++; $display("FAIL midop_release cyc%0d got sync=%b rise=%b fall=%b expected sync=%b no pulses", c, sync_out, rise, fall, RV);
      end
    end
  endtask

  task automatic test_violation();
    // Change just before an edge: settled value after LAT or LAT+1 edges.
    @(negedge clk); #4.905 async_in[0] = 1'b0;
    for (int e = 0; e < LAT + 1; e++) begin
      @(posedge clk); #1;
      checks++;
      if ($isunknown(sync_out)) begin errors++; $display("FAIL viol_setup_x edge%0d got %b expected no X", e, sync_out); end
    end
    checks++;
    if (sync_out !== 4'b0100) begin errors++; $display("FAIL viol_setup_val got %b expected 0100", sync_out); end
    repeat (2) step();
    // Change just after an edge.
    @(posedge clk); #0.05 async_in[0] = 1'b1;
    for (int e = 0; e < LAT + 1; e++) begin
      @(posedge clk); #1;
      checks++;
      if ($isunknown(sync_out)) begin errors++; $display("FAIL viol_hold_x edge%0d got %b expected no X", e, sync_out); end
    end
    checks++;
    if (sync_out !== RV) begin errors++; $display("FAIL viol_hold_val got %b expected %b", sync_out, RV); end
    repeat (2) step();
  endtask

`ifndef SYNC_BANK_FILTER_EN
  task automatic test_latency();
    @(negedge clk); async_in = 4'b0111;
    step();
    checks++;
    if (sync_out !== RV || rise !== 4'b0) begin errors++; $display("FAIL lat_e1 got sync=%b rise=%b expected sync=0101 rise=0000", sync_out, rise); end
    step();
    checks++;
    if (sync_out !== 4'b0111) begin errors++; $display("FAIL lat_e2_sync got %b expected 0111", sync_out); end
    checks++;
    if (rise !== 4'b0010 || fall !== 4'b0000) begin errors++; $display("FAIL lat_e2_pulse got rise=%b fall=%b expected rise=0010 fall=0000", rise, fall); end
    step();
    checks++;
    if (rise !== 4'b0 || fall !== 4'b0) begin errors++; $display("FAIL lat_e3_clear got rise=%b fall=%b expected 0", rise, fall); end
    @(negedge clk); async_in = RV;
    repeat (2) step();
    checks++;
    if (sync_out !== RV || fall !== 4'b0010 || rise !== 4'b0) begin
      errors++; $display("FAIL lat_back got sync=%b rise=%b fall=%b expected sync=0101 rise=0000 fall=0010", sync_out, rise, fall);
    end
    step();
    checks++;
    if (fall !== 4'b0) begin errors++; $display("FAIL lat_back_clear got fall=%b expected 0000", fall); end
  endtask

  task automatic test_multi();
    @(negedge clk); async_in = 4'b1010;
    step();
    checks++;
    if ({rise, fall} !== 8'h00) begin errors++; $display("FAIL multi_e1 got rise=%b fall=%b expected 0", rise, fall); end
    step();
    checks++;
    if (sync_out !== 4'b1010 || rise !== 4'b1010 || fall !== 4'b0101) begin
      errors++; $display("FAIL multi_e2 got sync=%b rise=%b fall=%b expected sync=1010 rise=1010 fall=0101", sync_out, rise, fall);
    end
    step();
    checks++;
    if ({rise, fall} !== 8'h00) begin errors++; $display("FAIL multi_e3 got rise=%b fall=%b expected 0", rise, fall); end
    @(negedge clk); async_in = RV;
    repeat (2) step();
    checks++;
    if (sync_out !== RV || rise !== 4'b0101 || fall !== 4'b1010) begin
      errors++; $display("FAIL multi_back got sync=%b rise=%b fall=%b expected sync=0101 rise=0101 fall=1010", sync_out, rise, fall);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] v;
    v = RV;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); v[3] = ~v[3]; async_in = v;
      step();
      checks++;
      if ({rise, fall} !== 8'h00) begin errors++; $display("FAIL b2b_e1 t%0d got rise=%b fall=%b expected 0", t, rise, fall); end
      step();
      checks++;
      if (sync_out !== v || rise !== (v[3] ? 4'b1000 : 4'b0000) || fall !== (v[3] ? 4'b0000 : 4'b1000)) begin
        errors++; $display("FAIL b2b_e2 t%0d got sync=%b rise=%b fall=%b expected sync=%b one pulse on bit3", t, sync_out, rise, fall, v);
      end
      step();
      checks++;
      if ({rise, fall} !== 8'h00) begin errors++; $display("FAIL b2b_e3 t%0d got rise=%b fall=%b expected 0", t, rise, fall); end
    end
  endtask
`else
  task automatic test_filter_glitch();
    @(negedge clk); async_in = 4'b0111;
    @(negedge clk);
    @(negedge clk); async_in = RV;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (sync_out !== RV || rise !== 4'b0 || fall !== 4'b0) begin
        errors++; $display("FAIL glitch cyc%0d got sync=%b rise=%b fall=%b expected sync=0101 no pulses", c, sync_out, rise, fall);
      end
    end
  endtask

  task automatic test_filter_sustained();
    @(negedge clk); async_in = 4'b0111;
    repeat (4) step();
    checks++;
    if (sync_out !== RV || rise !== 4'b0) begin errors++; $display("FAIL sust_e4 got sync=%b rise=%b expected sync=0101 rise=0000", sync_out, rise); end
    step();
    checks++;
    if (sync_out !== 4'b0111 || rise !== 4'b0010 || fall !== 4'b0) begin
      errors++; $display("FAIL sust_e5 got sync=%b rise=%b fall=%b expected sync=0111 rise=0010 fall=0000", sync_out, rise, fall);
    end
    step();
    checks++;
    if (rise !== 4'b0) begin errors++; $display("FAIL sust_e6 got rise=%b expected 0000", rise); end
    @(negedge clk); async_in = RV;
    repeat (5) step();
    checks++;
    if (sync_out !== RV || fall !== 4'b0010) begin errors++; $display("FAIL sust_back got sync=%b fall=%b expected sync=0101 fall=0010", sync_out, fall); end
    step();
    checks++;
    if (fall !== 4'b0) begin errors++; $display("FAIL sust_back_clear got fall=%b expected 0000", fall); end
  endtask

  task automatic test_filter_reset();
    @(negedge clk); async_in = 4'b0111;
    repeat (3) step();
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (sync_out !== RV || {rise, fall} !== 8'h00) begin
      errors++; $display("FAIL filt_rst got sync=%b rise=%b fall=%b expected sync=0101 no pulses", sync_out, rise, fall);
    end
    async_in = RV;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (sync_out !== RV || rise !== 4'b0 || fall !== 4'b0) begin
        errors++; $display("FAIL filt_rst_after cyc%0d got sync=%b rise=%b fall=%b expected sync=0101 no pulses", c, sync_out, rise, fall);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_violation();
`ifndef SYNC_BANK_FILTER_EN
    test_latency();
    test_multi();
    test_back_to_back();
`else
    test_filter_glitch();
    test_filter_sustained();
    test_filter_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
